cdc_multi_strobe: RTL and testbench

CDC_MULTI_STROBE -- requirements
Module: cdc_multi_strobe

---
 rtl/cdc_pkg.sv | 16 +
 rtl/cdc_strobe_channel.sv | 73 +++++++
 rtl/cdc_multi_strobe.sv | 77 +++++++
 tb/tb_cdc_multi_strobe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared encodings for the multi-channel strobe synchronizer: edge selection
// codes, the global arming state type and the pulse counter width.
package cdc_pkg;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_BOTH    = 2;

  localparam int CNT_W = 4;

  typedef enum logic {
    ARMING = 1'b0,
    RUN    = 1'b1
  } arm_state_t;

endpackage

// File: rtl/cdc_strobe_channel.sv
// One strobe channel: level synchronizer chain, edge detect, retriggerable
// pulse stretcher and the sticky / overrun flags.
module cdc_strobe_channel
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int EDGE_MODE   = EDGE_RISING,
  parameter int PULSE_LEN   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic src,
  input  logic clear,
  output logic strobe,
  output logic sticky,
  output logic overrun
);

  // Counter holds the pulse cycles still owed after the current one, so a
  // single-cycle pulse never leaves it nonzero and cannot report overrun.
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  logic [CNT_W-1:0] cnt_q;
  logic             last, prev;
  logic             edge_raw, hit, busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], src};
    end
  end

  assign last = sync_q[SYNC_STAGES-1];
  assign prev = sync_q[SYNC_STAGES-2];

  always_comb begin
    edge_raw = 1'b0;
    case (EDGE_MODE)
      EDGE_RISING:  edge_raw = prev & ~last;
      EDGE_FALLING: edge_raw = ~prev & last;
      default:      edge_raw = prev ^ last;
    endcase
  end

  assign hit  = run & edge_raw;
  assign busy = (cnt_q != '0);

  // A new detection outranks a coincident clear on both flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      strobe  <= 1'b0;
      sticky  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (hit) begin
        cnt_q <= RELOAD;
      end else if (busy) begin
        cnt_q <= cnt_q - ONE;
      end
      strobe  <= hit | busy;
      sticky  <= hit | (sticky & ~clear);
      overrun <= (hit & busy) | (overrun & ~clear);
    end
  end

endmodule

// File: rtl/cdc_multi_strobe.sv
// Multi-channel asynchronous level to destination-clock strobe converter with
// a global arming phase that masks edges while the synchronizers fill.
module cdc_multi_strobe
  import cdc_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 3,
  parameter int EDGE_MODE   = EDGE_RISING,
  parameter int PULSE_LEN   = 1
) (
  input  logic                dst_clk,
  input  logic                dst_rst,
  input  logic [CHANNELS-1:0] src_signal,
  input  logic [CHANNELS-1:0] dst_clear,
  output logic [CHANNELS-1:0] dst_strobe,
  output logic [CHANNELS-1:0] dst_sticky,
  output logic [CHANNELS-1:0] dst_overrun,
  output logic                dst_any
);

  localparam int AW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  arm_state_t    state, state_next;
  logic [AW-1:0] arm_cnt, arm_cnt_next;
  logic          run;

  always_ff @(posedge dst_clk) begin
    if (dst_rst) begin
      state   <= ARMING;
      arm_cnt <= '0;
    end else begin
      state   <= state_next;
      arm_cnt <= arm_cnt_next;
    end
  end

  // Stay in ARMING for SYNC_STAGES cycles: long enough for reset zeros in the
  // chains to be fully replaced by the live source levels.
  always_comb begin
    state_next   = state;
    arm_cnt_next = arm_cnt;
    case (state)
      ARMING: begin
        if (arm_cnt == AW'(SYNC_STAGES - 1)) begin
          state_next = RUN;
        end else begin
          arm_cnt_next = arm_cnt + AW'(1);
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run = (state == RUN);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    cdc_strobe_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE),
      .PULSE_LEN  (PULSE_LEN)
    ) u_ch (
      .clk    (dst_clk),
      .rst    (dst_rst),
      .run    (run),
      .src    (src_signal[i]),
      .clear  (dst_clear[i]),
      .strobe (dst_strobe[i]),
      .sticky (dst_sticky[i]),
      .overrun(dst_overrun[i])
    );
  end

  assign dst_any = |dst_strobe;

endmodule

// File: tb/tb_cdc_multi_strobe.sv
// Bench for cdc_multi_strobe: four differently parameterised instances share
// one stimulus stream and are each checked every cycle against a timeline model.
module tb_cdc_multi_strobe;

  localparam int CH = 4;
  localparam int ND = 4;
  localparam int S_OF [ND] = '{3, 3, 2, 3};
  localparam int M_OF [ND] = '{0, 2, 0, 1};
  localparam int P_OF [ND] = '{1, 3, 4, 5};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] src = '0;
  logic [CH-1:0] clr = '0;

  logic [CH-1:0] stb [ND];
  logic [CH-1:0] stk [ND];
  logic [CH-1:0] ovr [ND];
  logic          any_o [ND];

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    cdc_multi_strobe #(
      .CHANNELS   (CH),
      .SYNC_STAGES(S_OF[d]),
      .EDGE_MODE  (M_OF[d]),
      .PULSE_LEN  (P_OF[d])
    ) u_dut (
      .dst_clk    (clk),
      .dst_rst    (rst),
      .src_signal (src),
      .dst_clear  (clr),
      .dst_strobe (stb[d]),
      .dst_sticky (stk[d]),
      .dst_overrun(ovr[d]),
      .dst_any    (any_o[d])
    );
  end

  // Reference: history of sampled source levels since reset release, plus the
  // last cycle index each channel's pulse is owed up to.
  logic [CH-1:0] cap_q [$];
  int            end_c [ND][CH];
  logic [CH-1:0] m_stb [ND];
  logic [CH-1:0] m_stk [ND];
  logic [CH-1:0] m_ovr [ND];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic [CH-1:0] s, input logic [CH-1:0] c);
    int   idx, st;
    logic cur, old, hit, ovev;
    if (r) begin
      cap_q.delete();
      for (int d = 0; d < ND; d++) begin
        for (int k = 0; k < CH; k++) end_c[d][k] = -1;
        m_stb[d] = '0;
        m_stk[d] = '0;
        m_ovr[d] = '0;
      end
    end else begin
      cap_q.push_back(s);
      idx = cap_q.size() - 1;
      for (int d = 0; d < ND; d++) begin
        st = S_OF[d];
        for (int k = 0; k < CH; k++) begin
          hit = 1'b0;
          if (idx >= st) begin
            cur = cap_q[idx - st + 1][k];
            old = cap_q[idx - st][k];
            if (M_OF[d] == 0)      hit = cur & ~old;
            else if (M_OF[d] == 1) hit = ~cur & old;
            else                   hit = cur ^ old;
          end
          ovev = hit && (end_c[d][k] >= idx);
          if (hit) end_c[d][k] = idx + P_OF[d] - 1;
          m_stk[d][k] = hit  ? 1'b1 : (c[k] ? 1'b0 : m_stk[d][k]);
          m_ovr[d][k] = ovev ? 1'b1 : (c[k] ? 1'b0 : m_ovr[d][k]);
          m_stb[d][k] = (idx <= end_c[d][k]);
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [CH-1:0] s, input logic [CH-1:0] c);
    rst = r;
    src = s;
    clr = c;
    @(posedge clk);
    model_update(r, s, c);
    #1;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d strobe", d), stb[d], m_stb[d]);
      check($sformatf("d%0d sticky", d), stk[d], m_stk[d]);
      check($sformatf("d%0d overrun", d), ovr[d], m_ovr[d]);
      check($sformatf("d%0d any", d), any_o[d], |m_stb[d]);
    end
  endtask

  task automatic reset_dut(input logic [CH-1:0] s);
    for (int k = 0; k < 3; k++) step(1'b1, s, '0);
  endtask

  typedef struct {
    logic          rst;
    logic [CH-1:0] src;
    logic [CH-1:0] clr;
    logic [CH-1:0] exp_stb;
    logic [CH-1:0] exp_stk;
  } vec_t;

  vec_t          tbl [14];
  int            highs, rises, n_any;
  logic          prev_b, found;
  logic [CH-1:0] cur_src, tog, cl;
  logic [2:0]    seq34 [3];

  initial begin
    // Default instance (rising, PULSE_LEN=1, 3 stages): capture at E0, pulse at E0+2.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h1};
    tbl[7]  = '{1'b0, 4'h1, 4'h0, 4'h0, 4'h1};
    tbl[8]  = '{1'b0, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 4'h7, 4'h0, 4'h0, 4'h0};
    tbl[10] = '{1'b0, 4'h7, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 4'h7, 4'h0, 4'h6, 4'h6};
    tbl[12] = '{1'b0, 4'h7, 4'h0, 4'h0, 4'h6};
    tbl[13] = '{1'b0, 4'h7, 4'hF, 4'h0, 4'h0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rst, tbl[i].src, tbl[i].clr);
      check($sformatf("tbl[%0d] strobe", i), stb[0], tbl[i].exp_stb);
      check($sformatf("tbl[%0d] sticky", i), stk[0], tbl[i].exp_stk);
    end

    // Both-edge instance, PULSE_LEN=3: rise then fall ten cycles later.
    reset_dut('0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'h0, '0);
    highs = 0; rises = 0; prev_b = 1'b0;
    for (int k = 0; k < 25; k++) begin
      step(1'b0, (k < 10) ? 4'h2 : 4'h0, '0);
      if (stb[1][1]) highs++;
      if (stb[1][1] && !prev_b) rises++;
      prev_b = stb[1][1];
    end
    check("both-edge high cycles", highs, 6);
    check("both-edge pulse count", rises, 2);
    check("both-edge overrun", ovr[1][1], 1'b0);

    // PULSE_LEN=4: rising edges two cycles apart retrigger into one 6-cycle pulse.
    reset_dut('0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'h0, '0);
    seq34[0] = 3'd1; seq34[1] = 3'd0; seq34[2] = 3'd1;
    highs = 0; rises = 0; prev_b = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, (k < 3) ? {3'b0, seq34[k][0]} : 4'h1, '0);
      if (stb[2][0]) highs++;
      if (stb[2][0] && !prev_b) rises++;
      prev_b = stb[2][0];
    end
    check("retrigger high cycles", highs, 6);
    check("retrigger pulse count", rises, 1);
    check("retrigger overrun", ovr[2][0], 1'b1);

    // Levels high through reset must not produce strobes after release.
    reset_dut(4'hF);
    n_any = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'hF, '0);
      for (int d = 0; d < ND; d++) if (any_o[d]) n_any++;
    end
    check("stable-high strobes", n_any, 0);
    check("stable-high sticky", stk[0], 4'h0);

    // Clear coinciding with a fresh detection on channel 2 loses to the set.
    reset_dut('0);
    for (int k = 0; k < 4; k++) step(1'b0, 4'h0, '0);
    for (int k = 0; k < 5; k++) step(1'b0, 4'h4, '0);
    for (int k = 0; k < 3; k++) step(1'b0, 4'h0, '0);
    step(1'b0, 4'h4, '0);
    step(1'b0, 4'h4, '0);
    step(1'b0, 4'h4, 4'h4);
    check("clear vs edge sticky", stk[0][2], 1'b1);
    check("clear vs edge strobe", stb[0][2], 1'b1);
    step(1'b0, 4'h4, '0);
    step(1'b0, 4'h4, 4'h4);
    check("clear alone sticky", stk[0][2], 1'b0);

    // Falling-edge PULSE_LEN=5 pulse cut short by reset in its second cycle.
    reset_dut(4'h8);
    for (int k = 0; k < 4; k++) step(1'b0, 4'h8, '0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(1'b0, 4'h0, '0);
      if (stb[3][3]) found = 1'b1;
    end
    check("fall pulse start", found, 1'b1);
    step(1'b0, 4'h0, '0);
    check("fall pulse cycle 2", stb[3], 4'h8);
    step(1'b1, 4'h0, '0);
    check("reset drops strobe", stb[3], 4'h0);
    n_any = 0;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'h0, '0);
      if (any_o[3]) n_any++;
    end
    check("no pulse after reset", n_any, 0);

    // Random toggles, clears and occasional resets against the model.
    reset_dut('0);
    cur_src = '0;
    for (int k = 0; k < 2000; k++) begin
      tog = '0;
      cl  = '0;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(3) == 0) tog[c] = 1'b1;
        if ($urandom_range(15) == 0) cl[c] = 1'b1;
      end
      cur_src = cur_src ^ tog;
      step(($urandom_range(299) == 0), cur_src, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
